score_frame_tx: RTL and testbench
=================================

# score_frame_tx

Game-over score reporter that drives the board UART TX line. On a rising edge of `start` (the game-over flag), it latches a 16-bit score. It then transmits a fixed 4-byte frame as 8N1 serial through its own bit-timing logic. Its `tx` output feeds the top-level TX pin path that is gated by game-over, so the PC receives a score report when a game ends.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
- `HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  game-over level; only a rising edge triggers a frame.
- `score`  in  16  score value; sampled on the trigger cycle only.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the cycle after the trigger until the frame ends.
- `done`  out  1  one-cycle pulse when the final stop bit completes.
- `frames`  out  8  count of completed frames; wraps 255→0.

## Operation
- Edge detect:
  - Register `start_d` (reset 0).
  - Trigger = `start & ~start_d & ~busy`.
  - If `start` is high on the first cycle after reset, that counts as a rising edge and triggers once.
- On trigger, latch the frame:
  - B0 = `HEADER`
  - B1 = `score[15:8]`
  - B2 = `score[7:0]`
  - B3 = `HEADER ^ score[15:8] ^ score[7:0]` (XOR checksum)
- `score` changes after the trigger have no effect on the current frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `busy`=0. On trigger → START, byte index = 0.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles → DATA, bit index = 0.
  - DATA: `tx` = current byte bit[bit index], LSB first, each bit for `CLKS_PER_BIT` cycles. After bit 7 → STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
    - If byte index < 3: increment byte index → START. There is no idle gap between bytes.
    - If byte index = 3: → IDLE, pulse `done`, increment `frames`.
- Bit timer: counter from 0 to `CLKS_PER_BIT`-1, cleared on every state or bit change. Width is `$clog2(CLKS_PER_BIT)`, minimum 1.
- Triggers while `busy` are ignored and are not queued. A new frame requires a fresh rising edge after `busy` falls.
- Reset mid-frame:
  - On the next clock, `tx`=1, `busy`=0, `done`=0, FSM returns to IDLE.
  - `frames` resets to 0. No partial byte completes.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `frames`=0, FSM=IDLE, `start_d`=0.
- All outputs are registered.
- Trigger sampled at edge N:
  - `busy`=1 and `tx`=0 (start bit) from edge N+1.
- Each byte occupies 10×`CLKS_PER_BIT` cycles.
- The frame occupies 40×`CLKS_PER_BIT` cycles, edges N+1 through N+40·`CLKS_PER_BIT`.
- At edge N+1+40·`CLKS_PER_BIT`:
  - `done`=1 for exactly one cycle.
  - `busy`=0.
  - `frames` increments.
  - `tx` stays 1.
- Earliest next trigger is that same edge, if `start` shows a fresh rise; `start_d` tracks `start` continuously.
- `done` and a new trigger may coincide. `done` still pulses, and the next frame starts on the following edge.

## Test plan
Run with `CLKS_PER_BIT`=4 and `HEADER`=8'hA5.
- Basic frame: reset, then `score`=16'h1234 and `start` 0→1.
  - `tx` decodes as A5, 12, 34, 83 (A5^12^34), LSB first, each bit 4 cycles wide.
  - `done` pulses at trigger+161; `frames`=1.
- Level hold: keep `start` high for 500 cycles.
  - Exactly one frame is sent; `frames`=1.
  - Drop and re-raise `start`: a second frame is sent; `frames`=2.
- Busy ignore: pulse `start` again 50 cycles into a frame, with `score` changed to 16'hFFFF.
  - The frame is unchanged (original score bytes); there is no second frame.
- Reset mid-frame: assert `rst` at cycle 70 of a frame.
  - Next cycle: `tx`=1, `busy`=0, `frames`=0.
  - `done` never pulses.
- Wrap and zero score: send 256 frames with `score`=0.
  - Each frame is A5, 00, 00, A5.
  - `frames` reads 255 then 0 after the 256th `done`.

Source files
------------

// File: rtl/score_frame_tx.sv
// Game-over score reporter: on a rising edge of start, latches the score and
// sends a 4-byte frame {HEADER, score_hi, score_lo, xor checksum} as 8N1 serial.
module score_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] score,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frames
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [31:0]      frame_q, frame_d;
  logic             start_d;
  logic             trigger_c;
  logic             bit_end_c;
  logic             frame_end_c;
  logic             frame_end_q;
  logic             tx_c;
  logic             busy_c;

  // Rising-edge trigger; only accepted while the serialiser is idle.
  assign trigger_c = start & ~start_d & (state_q == IDLE);
  assign bit_end_c = (cnt_q == CNT_LAST);

  // State, bit timer, indices and latched frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      start_d <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      start_d <= start;
    end
  end

  // Next-state and per-state line level; the frame is packed with B0 in bits [7:0].
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    byte_d      = byte_q;
    frame_d     = frame_q;
    frame_end_c = 1'b0;
    tx_c        = 1'b1;
    busy_c      = 1'b1;

    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        cnt_d  = '0;
        if (trigger_c) begin
          state_d = START;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          frame_d = {HEADER ^ score[15:8] ^ score[7:0], score[7:0], score[15:8], HEADER};
        end
      end

      START: begin
        tx_c = 1'b0;
        if (bit_end_c) begin
          state_d = DATA;
          bit_d   = 3'd0;
          cnt_d   = '0;
        end
      end

      DATA: begin
        tx_c = frame_q[{byte_q, bit_q}];
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        tx_c = 1'b1;
        if (bit_end_c) begin
          cnt_d = '0;
          if (byte_q == 2'd3) begin
            state_d     = IDLE;
            frame_end_c = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs; done/frames lag the final stop-bit edge by one cycle
  // so they line up with busy falling.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames      <= 8'd0;
      frame_end_q <= 1'b0;
    end else begin
      tx          <= tx_c;
      busy        <= busy_c;
      frame_end_q <= frame_end_c;
      done        <= frame_end_q;
      if (frame_end_q) begin
        frames <= frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_score_frame_tx.sv
// Self-checking bench for score_frame_tx with CLKS_PER_BIT=4, HEADER=A5.
module tb_score_frame_tx;

  localparam int C     = 4;
  localparam int FRAME = 40 * C;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] score;
  logic        tx;
  logic        busy;
  logic        done;
  logic [7:0]  frames;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  score_frame_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .score(score),
    .tx(tx), .busy(busy), .done(done), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: outputs as a function of the offset from the trigger edge.
  int         m_pos = -1;
  bit         m_start_d = 1'b0;
  logic [7:0] m_bytes [4];
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic [7:0] exp_frames = 8'd0;

  function automatic logic exp_bit(input int k);
    int slot, b, p;
    slot = k / C;
    b    = slot / 10;
    p    = slot % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_bytes[b][p-1];
  endfunction

  // Reference model stepped on each active edge.
  always @(posedge clk) begin
    bit trig;
    cyc = cyc + 1;
    if (rst) begin
      m_pos      = -1;
      m_start_d  = 1'b0;
      exp_tx     = 1'b1;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_frames = 8'd0;
    end else begin
      if (m_pos >= 0) m_pos++;
      if (m_pos > FRAME + 1) m_pos = -1;
      trig     = start && !m_start_d && !(m_pos >= 1 && m_pos <= FRAME);
      exp_busy = (m_pos >= 1 && m_pos <= FRAME);
      exp_tx   = exp_busy ? exp_bit(m_pos - 1) : 1'b1;
      exp_done = (m_pos == FRAME + 1);
      if (exp_done) exp_frames = exp_frames + 8'd1;
      if (trig) begin
        m_pos      = 0;
        m_bytes[0] = 8'hA5;
        m_bytes[1] = score[15:8];
        m_bytes[2] = score[7:0];
        m_bytes[3] = 8'hA5 ^ score[15:8] ^ score[7:0];
      end
      m_start_d = start;
    end
  end

  int done_count = 0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", 32'(tx), 32'(exp_tx));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("frames", 32'(frames), 32'(exp_frames));
      if (done === 1'b1) done_count++;
    end
  end

  // UART receiver decoding the DUT line into bytes, sampling mid-bit.
  logic [7:0] rx_q [$];
  bit         rx_idle = 1'b1;
  int         rx_cnt = 0;
  logic [7:0] rx_sh;
  always @(negedge clk) begin
    if (rst === 1'b1 || !chk_en) begin
      rx_idle = 1'b1;
    end else if (rx_idle) begin
      if (tx === 1'b0) begin
        rx_idle = 1'b0;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
        rx_sh[rx_cnt / C - 1] = tx;
      if (rx_cnt == 9 * C + C / 2) begin
        rx_q.push_back(rx_sh);
        rx_idle = 1'b1;
      end
    end
  end

  task automatic check_bytes(input string name, input logic [31:0] exp);
    logic [31:0] got;
    got = '0;
    if (rx_q.size() < 4) begin
      check({name, "_count"}, 32'(rx_q.size()), 32'd4);
      rx_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) got = {got[23:0], rx_q.pop_front()};
      check(name, got, exp);
    end
  endtask

  int done_cyc;
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen     = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int t0, dc;
    rst = 1'b1; start = 1'b0; score = 16'h0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frames", 32'(frames), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame, start held high as a level.
    rx_q.delete();
    score = 16'h1234; start = 1'b1; t0 = cyc + 1;
    wait_done(400);
    check("done_latency", 32'(done_cyc - t0), 32'd161);
    check("frames_1", 32'(frames), 32'd1);
    check_bytes("basic_bytes", 32'hA5123483);
    repeat (340) @(negedge clk);
    check("hold_frames", 32'(frames), 32'd1);
    check("hold_rx_empty", 32'(rx_q.size()), 32'd0);

    // Re-raise for a second frame.
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    wait_done(400);
    check("frames_2", 32'(frames), 32'd2);
    check_bytes("second_bytes", 32'hA5123483);

    // Retrigger with a new score while busy must be ignored.
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; t0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    while (cyc < t0 + 50) @(negedge clk);
    score = 16'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(400);
    check_bytes("ignore_bytes", 32'hA5123483);
    check("frames_3", 32'(frames), 32'd3);
    repeat (250) @(negedge clk);
    check("ignore_frames", 32'(frames), 32'd3);
    check("ignore_rx_empty", 32'(rx_q.size()), 32'd0);

    // Reset in the middle of a frame.
    score = 16'h1234; start = 1'b1; t0 = cyc + 1;
    @(negedge clk); start = 1'b0;
    while (cyc < t0 + 70) @(negedge clk);
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_frames", 32'(frames), 32'd0);
    rst = 1'b0;
    dc = done_count;
    repeat (250) @(negedge clk);
    check("rstmid_no_done", 32'(done_count - dc), 32'd0);
    check("rstmid_frames_after", 32'(frames), 32'd0);

    // 256 back-to-back zero-score frames; each retrigger lands on the done edge.
    rx_q.delete();
    score = 16'h0000; start = 1'b1; t0 = cyc + 1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); start = 1'b0;
      while (cyc < t0 + FRAME) @(negedge clk);
      check_bytes("zero_bytes", 32'hA50000A5);
      if (i == 255) check("frames_255", 32'(frames), 32'd255);
      if (i < 255) start = 1'b1;
      t0 = t0 + FRAME + 1;
    end
    @(negedge clk);
    check("wrap_done", 32'(done), 32'd1);
    check("wrap_frames_0", 32'(frames), 32'd0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
